// File: rtl/dca_matrix_pkg.sv
// Shared definitions for the DCA matrix load path.
//   - default geometry (rows per matrix, scalar width, ring depth)
//   - width helpers: row width, matrix width, row/slot index width
//   - load FSM state encoding
package dca_matrix_pkg;

    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_BW_SCALAR   = 32;
    localparam int DEF_DEPTH       = 2;

    // state | meaning
    // FILL  | accepting LSU rows into the current slot
    // PAD   | writing zero rows after an early wlast (zero-pad build only)
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PAD  = 1'b1
    } load_state_t;

    // Index width that stays >= 1 so single-entry arrays still get a port.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bw_row(input int m, input int s);
        return m * s;
    endfunction

    function automatic int bw_matrix(input int m, input int s);
        return m * m * s;
    endfunction

    function automatic int bw_row_idx(input int m);
        return idx_bits(m);
    endfunction

endpackage

// File: rtl/dca_matrix_slot_array.sv
// Ring-buffer storage: DEPTH slots of MATRIX_SIZE rows each. Storage is not reset.
// Ports:
//   clk      clock
//   wr_en    write one row this cycle
//   wr_slot  slot to write
//   wr_row   row within slot (row 0 lands in the matrix MSBs)
//   wr_data  row data
//   rd_slot  slot presented on rd_data
//   rd_data  whole matrix of rd_slot, row 0 in MSBs (combinational)
module dca_matrix_slot_array
    import dca_matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int BW_SCALAR   = DEF_BW_SCALAR,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          wr_en,
    input  logic [idx_bits(DEPTH)-1:0]                    wr_slot,
    input  logic [bw_row_idx(MATRIX_SIZE)-1:0]            wr_row,
    input  logic [bw_row(MATRIX_SIZE, BW_SCALAR)-1:0]     wr_data,
    input  logic [idx_bits(DEPTH)-1:0]                    rd_slot,
    output logic [bw_matrix(MATRIX_SIZE, BW_SCALAR)-1:0]  rd_data
);

    localparam int ROW_BITS = bw_row(MATRIX_SIZE, BW_SCALAR);
    localparam int MAT_BITS = bw_matrix(MATRIX_SIZE, BW_SCALAR);

    logic [ROW_BITS-1:0] mem [DEPTH][MATRIX_SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_row] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            rd_data[MAT_BITS-1-r*ROW_BITS -: ROW_BITS] = mem[rd_slot][r];
        end
    end

endmodule

// File: rtl/dca_matrix_load_buffer.sv
// Assembles LSU tensor-row streams into whole matrices and queues up to DEPTH of
// them in a ring buffer for the engine, so loads can run ahead of compute.
// Optional feature macro: DCA_LOAD_BUFFER_ZERO_PAD_EN
//   defined   : early wlast enters PAD and the remaining rows are written zero
//   undefined : early wlast commits at once (stale tail rows) and pulses error_short
// Ports:
//   clk, rstnn (sync active-low), clear (sync flush), enable (freeze when 0)
//   busy                      matrices held, partial fill or padding in progress
//   load_tensor_row_*         row write channel from the LSU (valid/ready/last/data)
//   loadreg_rready/rrequest   head matrix available / pop it
//   loadreg_rdata             head matrix, row 0 in MSBs
//   loadreg_num               complete matrices held
//   error_nolast/error_short  one-cycle framing error pulses
//
// state | meaning
// FILL  | accepting rows; commits on row M-1 or on wlast
// PAD   | writing zero rows up to row M-1, LSU stalled
module dca_matrix_load_buffer
    import dca_matrix_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int BW_SCALAR   = DEF_BW_SCALAR,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rstnn,
    input  logic                                          clear,
    input  logic                                          enable,
    output logic                                          busy,
    output logic                                          load_tensor_row_wready,
    input  logic                                          load_tensor_row_wvalid,
    input  logic                                          load_tensor_row_wlast,
    input  logic [bw_row(MATRIX_SIZE, BW_SCALAR)-1:0]     load_tensor_row_wdata,
    output logic                                          loadreg_rready,
    input  logic                                          loadreg_rrequest,
    output logic [bw_matrix(MATRIX_SIZE, BW_SCALAR)-1:0]  loadreg_rdata,
    output logic [$clog2(DEPTH+1)-1:0]                    loadreg_num,
    output logic                                          error_nolast,
    output logic                                          error_short
);

    localparam int ROW_BITS = bw_row(MATRIX_SIZE, BW_SCALAR);
    localparam int IDX_BITS = bw_row_idx(MATRIX_SIZE);
    localparam int PTR_BITS = idx_bits(DEPTH);
    localparam int NUM_BITS = $clog2(DEPTH + 1);

    load_state_t         state;
    logic [IDX_BITS-1:0] row_cnt;
    logic [PTR_BITS-1:0] wptr;
    logic [PTR_BITS-1:0] rptr;
    logic [NUM_BITS-1:0] num;

    logic                last_row;
    logic                accept;
    logic                pad_write;
    logic                commit;
    logic                pop;
    logic                wr_en;
    logic [ROW_BITS-1:0] wr_data;

    function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign last_row  = (row_cnt == IDX_BITS'(MATRIX_SIZE - 1));

    assign load_tensor_row_wready = enable & (state == ST_FILL) & (num < NUM_BITS'(DEPTH));

    // clear wins over accept/pad/pop, so everything below is gated by it.
    assign accept    = load_tensor_row_wvalid & load_tensor_row_wready & ~clear;
    assign pad_write = enable & (state == ST_PAD) & ~clear;

`ifdef DCA_LOAD_BUFFER_ZERO_PAD_EN
    assign commit = (accept & last_row) | (pad_write & last_row);
`else
    assign commit = (accept & (last_row | load_tensor_row_wlast)) | (pad_write & last_row);
`endif

    assign loadreg_rready = (num != '0);
    assign pop            = loadreg_rrequest & loadreg_rready & enable & ~clear;
    assign busy           = (num != '0) | (row_cnt != '0) | (state == ST_PAD);
    assign loadreg_num    = num;

    // Storage keeps its contents through reset, but nothing is written while held in reset.
    assign wr_en   = rstnn & (accept | pad_write);
    assign wr_data = pad_write ? '0 : load_tensor_row_wdata;

    dca_matrix_slot_array #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .BW_SCALAR   (BW_SCALAR),
        .DEPTH       (DEPTH)
    ) u_slots (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_slot (wptr),
        .wr_row  (row_cnt),
        .wr_data (wr_data),
        .rd_slot (rptr),
        .rd_data (loadreg_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state        <= ST_FILL;
            row_cnt      <= '0;
            wptr         <= '0;
            rptr         <= '0;
            num          <= '0;
            error_nolast <= 1'b0;
            error_short  <= 1'b0;
        end else begin
            error_nolast <= 1'b0;
            error_short  <= 1'b0;
            if (clear) begin
                state   <= ST_FILL;
                row_cnt <= '0;
                wptr    <= '0;
                rptr    <= '0;
                num     <= '0;
            end else begin
                if (enable) begin
                    case (state)
                        ST_FILL: begin
                            if (accept) begin
                                if (last_row) begin
                                    row_cnt      <= '0;
                                    error_nolast <= ~load_tensor_row_wlast;
                                end else if (load_tensor_row_wlast) begin
`ifdef DCA_LOAD_BUFFER_ZERO_PAD_EN
                                    state   <= ST_PAD;
                                    row_cnt <= row_cnt + 1'b1;
`else
                                    row_cnt     <= '0;
                                    error_short <= 1'b1;
`endif
                                end else begin
                                    row_cnt <= row_cnt + 1'b1;
                                end
                            end
                        end
                        ST_PAD: begin
                            if (last_row) begin
                                state   <= ST_FILL;
                                row_cnt <= '0;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end
                        default: state <= ST_FILL;
                    endcase
                end

                if (commit) begin
                    wptr <= ptr_next(wptr);
                end
                if (pop) begin
                    rptr <= ptr_next(rptr);
                end
                case ({commit, pop})
                    2'b10:   num <= num + 1'b1;
                    2'b01:   num <= num - 1'b1;
                    default: num <= num;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_load_buffer.sv
// Bench for dca_matrix_load_buffer at M=4, S=8, DEPTH=2: directed scenarios followed
// by random traffic, all checked against a matrix-level reference model.
module tb_dca_matrix_load_buffer;

    localparam int M    = 4;
    localparam int S    = 8;
    localparam int D    = 2;
    localparam int ROWB = M * S;
    localparam int MATB = M * M * S;

    logic            clk = 1'b0;
    logic            rstnn = 1'b0;
    logic            clear = 1'b0;
    logic            enable = 1'b0;
    logic            busy;
    logic            wready;
    logic            wvalid = 1'b0;
    logic            wlast = 1'b0;
    logic [ROWB-1:0] wdata = '0;
    logic            rready;
    logic            rrequest = 1'b0;
    logic [MATB-1:0] rdata;
    logic [1:0]      num;
    logic            error_nolast;
    logic            error_short;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: matrices per slot, known-row map, queue bookkeeping.
    logic [ROWB-1:0] mem   [D][M];
    bit              known [D][M];
    int  m_row = 0, m_wslot = 0, m_rslot = 0, m_num = 0;
    bit  m_pad = 0, m_enl = 0, m_esh = 0;

    always #5 clk = ~clk;

    dca_matrix_load_buffer #(
        .MATRIX_SIZE (M),
        .BW_SCALAR   (S),
        .DEPTH       (D)
    ) dut (
        .clk                    (clk),
        .rstnn                  (rstnn),
        .clear                  (clear),
        .enable                 (enable),
        .busy                   (busy),
        .load_tensor_row_wready (wready),
        .load_tensor_row_wvalid (wvalid),
        .load_tensor_row_wlast  (wlast),
        .load_tensor_row_wdata  (wdata),
        .loadreg_rready         (rready),
        .loadreg_rrequest       (rrequest),
        .loadreg_rdata          (rdata),
        .loadreg_num            (num),
        .error_nolast           (error_nolast),
        .error_short            (error_short)
    );

    task automatic chk(input string tag, input logic [MATB-1:0] obs, input logic [MATB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the falling edge, check wready, advance the
    // model, then check the registered outputs at the next falling edge.
    task automatic step(input bit v, input bit l, input logic [ROWB-1:0] d,
                        input bit rq, input bit en, input bit clr, input bit rs);
        bit exp_wr;
        bit commit;
        bit pop;
        rstnn = rs; clear = clr; enable = en;
        wvalid = v; wlast = l; wdata = d; rrequest = rq;
        #1;
        exp_wr = en && !m_pad && (m_num < D);
        chk("wready", wready, exp_wr);

        commit = 0;
        pop    = 0;
        if (!rs || clr) begin
            m_pad = 0; m_row = 0; m_wslot = 0; m_rslot = 0; m_num = 0;
            m_enl = 0; m_esh = 0;
        end else begin
            m_enl = 0;
            m_esh = 0;
            if (en) begin
                if (m_pad) begin
                    mem[m_wslot][m_row]   = '0;
                    known[m_wslot][m_row] = 1;
                    if (m_row == M - 1) begin
                        commit = 1;
                        m_pad  = 0;
                    end else begin
                        m_row++;
                    end
                end else if (v && exp_wr) begin
                    mem[m_wslot][m_row]   = d;
                    known[m_wslot][m_row] = 1;
                    if (m_row == M - 1) begin
                        commit = 1;
                        m_enl  = !l;
                    end else if (l) begin
`ifdef DCA_LOAD_BUFFER_ZERO_PAD_EN
                        m_pad = 1;
                        m_row++;
`else
                        commit = 1;
                        m_esh  = 1;
`endif
                    end else begin
                        m_row++;
                    end
                end
                pop = rq && (m_num > 0);
            end
            if (commit) begin
                m_wslot = (m_wslot + 1) % D;
                m_row   = 0;
                m_num++;
            end
            if (pop) begin
                m_rslot = (m_rslot + 1) % D;
                m_num--;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("rready", rready, m_num > 0);
        chk("num", num, m_num);
        chk("busy", busy, (m_num != 0) || (m_row != 0) || m_pad);
        chk("error_nolast", error_nolast, m_enl);
        chk("error_short", error_short, m_esh);
        if (m_num > 0) begin
            for (int r = 0; r < M; r++) begin
                if (known[m_rslot][r]) chk("rdata_row", rdata[MATB-1-r*ROWB -: ROWB], mem[m_rslot][r]);
            end
        end
    endtask

    task automatic row(input logic [ROWB-1:0] d, input bit l);
        step(1, l, d, 0, 1, 0, 1);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 1, 0, 1);
    endtask

    task automatic pop1();
        step(0, 0, '0, 1, 1, 0, 1);
    endtask

    initial begin
        // reset
        step(0, 0, '0, 0, 0, 0, 0);
        step(0, 0, '0, 0, 1, 0, 0);
        chk("reset_rready", rready, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // 1: one full matrix with wlast on the last row
        row(32'h11111111, 0);
        row(32'h22222222, 0);
        row(32'h33333333, 0);
        row(32'h44444444, 1);
        chk("t1_rdata", rdata, 128'h11111111_22222222_33333333_44444444);
        chk("t1_num", num, 2'd1);
        pop1();

        // 2: fill both slots, third matrix stalls until a pop
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < M; r++) row(32'hA0000000 + 32'(k * 16 + r), r == M - 1);
        chk("t2_full_wready", wready, 1'b0);
        chk("t2_full_num", num, 2'd2);
        step(1, 0, 32'hC0000000, 1, 1, 0, 1);
        chk("t2_pop_num", num, 2'd1);
        chk("t2_after_pop_wready", wready, 1'b1);
        for (int r = 0; r < M; r++) row(32'hC0000000 + 32'(r), r == M - 1);
        chk("t2_third_num", num, 2'd2);
        pop1();
        pop1();

        // 3: short matrix
        row(32'hAAAAAAAA, 0);
        row(32'hBBBBBBBB, 1);
`ifdef DCA_LOAD_BUFFER_ZERO_PAD_EN
        chk("t3_pad_wready", wready, 1'b0);
        idle();
        chk("t3_pad_wready2", wready, 1'b0);
        idle();
        chk("t3_rdata", rdata, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000);
        chk("t3_error_short", error_short, 1'b0);
`else
        chk("t3_error_short", error_short, 1'b1);
        chk("t3_num", num, 2'd1);
        chk("t3_rdata_head", rdata[MATB-1 -: 64], 64'hAAAAAAAA_BBBBBBBB);
`endif
        pop1();

        // 4: no wlast on row M-1
        for (int r = 0; r < M; r++) row(32'hD0000000 + 32'(r), 0);
        chk("t4_error_nolast", error_nolast, 1'b1);
        row(32'hE0000000, 0);
        chk("t4_error_cleared", error_nolast, 1'b0);
        for (int r = 1; r < M; r++) row(32'hE0000000 + 32'(r), r == M - 1);
        pop1();
        chk("t4_next_slot", rdata, 128'hE0000000_E0000001_E0000002_E0000003);
        pop1();

        // 5: pop and commit in the same cycle
        for (int r = 0; r < M; r++) row(32'hF0000000 + 32'(r), r == M - 1);
        for (int r = 0; r < M - 1; r++) row(32'h50000000 + 32'(r), 0);
        step(1, 1, 32'h50000003, 1, 1, 0, 1);
        chk("t5_num", num, 2'd1);
        chk("t5_rdata", rdata, 128'h50000000_50000001_50000002_50000003);
        pop1();

        // 6: clear mid-fill, then reset mid-PAD
        row(32'h60000000, 0);
        row(32'h60000001, 0);
        step(0, 0, '0, 0, 1, 1, 1);
        chk("t6_clear_num", num, 2'd0);
        chk("t6_clear_busy", busy, 1'b0);
        for (int r = 0; r < M; r++) row(32'h70000000 + 32'(r), r == M - 1);
        chk("t6_rdata", rdata, 128'h70000000_70000001_70000002_70000003);
        pop1();
        row(32'h80000000, 0);
        row(32'h80000001, 1);
        step(0, 0, '0, 0, 1, 0, 0);
        chk("t6_reset_busy", busy, 1'b0);
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 9,
                 $urandom_range(0, 99) < 3, !($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
